// File: rtl/booth_divider_pkg.sv
// Shared widths, FSM state encoding and counter type for the signed divider.
package div_pkg;

  localparam int WIDTH_INPUT  = 16;
  localparam int WIDTH_OUTPUT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } div_state_e;

  typedef logic [4:0] div_count_t;

endpackage

// File: rtl/booth_divider_nr_div_step.sv
// One combinational non-restoring division step on magnitudes.
module nr_div_step
  import div_pkg::*;
(
  input  logic [WIDTH_INPUT:0]   i_rem,
  input  logic                   i_bit,
  input  logic [WIDTH_INPUT-1:0] i_divisor,
  output logic [WIDTH_INPUT:0]   o_rem,
  output logic                   o_qbit
);

  logic [WIDTH_INPUT+1:0] w_shift;
  logic [WIDTH_INPUT+1:0] w_div;
  logic [WIDTH_INPUT+1:0] w_next;

  // One guard bit above the 17-bit partial remainder keeps 2*P+bit exact.
  assign w_shift = {i_rem, i_bit};
  assign w_div   = {2'b00, i_divisor};
  assign w_next  = i_rem[WIDTH_INPUT] ? (w_shift + w_div) : (w_shift - w_div);

  assign o_rem  = w_next[WIDTH_INPUT:0];
  assign o_qbit = ~w_next[WIDTH_INPUT+1];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed 32/16 divider: magnitude non-restoring core, one quotient bit per clock,
// sign and overflow handling in a final fix-up cycle.
module booth_divider
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [WIDTH_OUTPUT-1:0] in_dividend,
  input  logic [WIDTH_INPUT-1:0]  in_divisor,
  output logic                    busy,
  output logic                    valid_out,
  output logic [WIDTH_INPUT-1:0]  quotient,
  output logic [WIDTH_INPUT-1:0]  remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  div_state_e             r_state;
  div_count_t             r_count;
  logic [WIDTH_INPUT-1:0] r_div_mag;
  logic [WIDTH_INPUT:0]   r_prem;
  logic [WIDTH_INPUT-1:0] r_dvd_lo;
  logic [WIDTH_INPUT-1:0] r_quo;
  logic                   r_q_neg;
  logic                   r_r_neg;
  logic                   r_dbz;
  logic                   r_ovf_pre;

  logic                   r_busy;
  logic                   r_valid_out;
  logic [WIDTH_INPUT-1:0] r_quotient;
  logic [WIDTH_INPUT-1:0] r_remainder;
  logic                   r_div_by_zero;
  logic                   r_overflow;

  logic [WIDTH_OUTPUT-1:0] w_dvd_mag;
  logic [WIDTH_INPUT-1:0]  w_dsr_mag;
  logic [WIDTH_INPUT:0]    w_next_rem;
  logic                    w_qbit;
  logic [WIDTH_INPUT-1:0]  w_rem_mag;
  logic                    w_ovf_post;
  logic                    w_ovf;

  // -2^31 maps to 0x8000_0000, which the unsigned magnitude holds exactly.
  assign w_dvd_mag = in_dividend[WIDTH_OUTPUT-1] ? (~in_dividend + 1'b1) : in_dividend;
  assign w_dsr_mag = in_divisor[WIDTH_INPUT-1]   ? (~in_divisor + 1'b1)  : in_divisor;

  nr_div_step u_step (
    .i_rem     (r_prem),
    .i_bit     (r_dvd_lo[WIDTH_INPUT-1]),
    .i_divisor (r_div_mag),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  assign w_rem_mag  = r_prem[WIDTH_INPUT] ? (r_prem[WIDTH_INPUT-1:0] + r_div_mag)
                                          : r_prem[WIDTH_INPUT-1:0];
  // A negative quotient may reach magnitude 0x8000; a positive one may not.
  assign w_ovf_post = r_q_neg ? (r_quo > 16'h8000) : (r_quo > 16'h7FFF);
  assign w_ovf      = ~r_dbz & (r_ovf_pre | w_ovf_post);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_div_mag     <= '0;
      r_prem        <= '0;
      r_dvd_lo      <= '0;
      r_quo         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf_pre     <= 1'b0;
      r_busy        <= 1'b0;
      r_valid_out   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid_out <= 1'b0;
          if (valid_in) begin
            r_div_mag <= w_dsr_mag;
            r_prem    <= {1'b0, w_dvd_mag[WIDTH_OUTPUT-1:WIDTH_INPUT]};
            r_dvd_lo  <= w_dvd_mag[WIDTH_INPUT-1:0];
            r_quo     <= '0;
            r_q_neg   <= in_dividend[WIDTH_OUTPUT-1] ^ in_divisor[WIDTH_INPUT-1];
            r_r_neg   <= in_dividend[WIDTH_OUTPUT-1];
            r_dbz     <= (in_divisor == '0);
            r_ovf_pre <= (w_dvd_mag[WIDTH_OUTPUT-1:WIDTH_INPUT] >= w_dsr_mag);
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= ITER;
          end
        end
        ITER: begin
          r_prem   <= w_next_rem;
          r_quo    <= {r_quo[WIDTH_INPUT-2:0], w_qbit};
          r_dvd_lo <= {r_dvd_lo[WIDTH_INPUT-2:0], 1'b0};
          r_count  <= r_count + 1'b1;
          if (r_count == 5'd15) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dbz || w_ovf) begin
            r_quotient  <= '0;
            r_remainder <= '0;
          end else begin
            r_quotient  <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
            r_remainder <= r_r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
          end
          r_div_by_zero <= r_dbz;
          r_overflow    <= w_ovf;
          r_valid_out   <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign valid_out   = r_valid_out;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
